fixed_to_double_conv: RTL and testbench



---
 rtl/fixed_to_double_conv_pkg.sv | 35 +++
 rtl/fixed_to_double_conv_if.sv | 31 +++
 rtl/fixed_to_double_conv_pack_round.sv | 60 ++++++
 rtl/fixed_to_double_conv.sv | 118 +++++++++++
 tb/tb_fixed_to_double_conv.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_to_double_conv_pkg.sv
// ============================================================================
// Module      : fp64_pkg
// Description : Shared binary64 field layout constants and the converter
//               state enumeration used by the fixed-to-double converters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp64_pkg;

  // binary64 format
  localparam int DBL_BIAS   = 1023;
  localparam int DBL_EXP_W  = 11;
  localparam int DBL_FRAC_W = 52;

  // Bit positions inside the packed word
  localparam int DBL_SIGN_POS = 63;
  localparam int DBL_EXP_MSB  = 62;
  localparam int DBL_EXP_LSB  = 52;
  localparam int DBL_FRAC_MSB = 51;
  localparam int DBL_FRAC_LSB = 0;

  // Exponent arithmetic width (signed, wide enough for any legal parameter mix)
  localparam int EXP_CALC_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_PACK = 2'd2,
    ST_HOLD = 2'd3
  } conv_state_e;

endpackage

`default_nettype wire

// File: rtl/fixed_to_double_conv_if.sv
// ============================================================================
// Module      : fixed_to_double_conv_if
// Description : Sample-in / double-out handshake bundle of the converter.
//               master = producer/consumer side, slave = converter side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fixed_to_double_conv_if #(
  parameter int IN_W = 16
);
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     out_double;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_double, out_valid, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_double, out_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/fixed_to_double_conv_pack_round.sv
// ============================================================================
// Module      : fp64_pack_round
// Description : Combinational packer. Takes a normalised magnitude (leading
//               one in the MSB, or all zero), a sign and an unbiased exponent
//               and returns the round-to-nearest-even binary64 word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp64_pack_round
  import fp64_pkg::*;
#(
  parameter int MAG_W = 16
) (
  input  logic [MAG_W-1:0]             mag_i,
  input  logic                         sign_i,
  input  logic signed [EXP_CALC_W-1:0] exp_i,
  output logic [63:0]                  double_o
);

  // Bits below the hidden one, followed by a zero guard slot and enough
  // zero padding so the fraction/guard/sticky slices exist for any MAG_W.
  localparam int EXT_W = MAG_W - 1 + DBL_FRAC_W + 1;

  logic [EXT_W-1:0]      w_ext;
  logic [DBL_FRAC_W-1:0] w_frac;
  logic                  w_guard;
  logic                  w_sticky;
  logic                  w_round_up;
  logic [DBL_FRAC_W:0]   w_frac_rnd;
  logic [DBL_EXP_W-1:0]  w_exp_b;
  logic                  w_zero;

  assign w_ext      = {mag_i[MAG_W-2:0], {(DBL_FRAC_W + 1){1'b0}}};
  assign w_frac     = w_ext[EXT_W-1 -: DBL_FRAC_W];
  assign w_guard    = w_ext[EXT_W-DBL_FRAC_W-1];
  assign w_sticky   = |w_ext[EXT_W-DBL_FRAC_W-2:0];
  assign w_round_up = w_guard & (w_sticky | w_frac[0]);
  assign w_frac_rnd = {1'b0, w_frac} + (DBL_FRAC_W + 1)'(w_round_up);

  // A carry out of the fraction leaves the fraction field at zero and bumps the exponent
  assign w_exp_b = DBL_EXP_W'(exp_i + EXP_CALC_W'(DBL_BIAS)
                              + EXP_CALC_W'(w_frac_rnd[DBL_FRAC_W]));

  // Normalised input: a clear MSB can only mean the magnitude is zero
  assign w_zero = ~mag_i[MAG_W-1];

  // Assemble the word; zero always encodes as +0
  always_comb begin
    double_o = 64'h0;
    if (!w_zero) begin
      double_o[DBL_SIGN_POS]                = sign_i;
      double_o[DBL_EXP_MSB:DBL_EXP_LSB]     = w_exp_b;
      double_o[DBL_FRAC_MSB:DBL_FRAC_LSB]   = w_frac_rnd[DBL_FRAC_W-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fixed_to_double_conv.sv
// ============================================================================
// Module      : fixed_to_double_conv
// Description : Fixed-point (Q-format, signed or unsigned) to IEEE-754
//               binary64 converter with a one-shift-per-cycle normaliser and
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fixed_to_double_conv
  import fp64_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int FRAC_BITS = 15,
  parameter int SIGNED    = 1
) (
  input  logic                    clk_operation,
  input  logic                    rst,
  fixed_to_double_conv_if.slave   bus
);

  localparam int SH_W = $clog2(IN_W);
  // Unbiased exponent of an input whose leading one is already in the MSB
  localparam logic signed [EXP_CALC_W-1:0] c_EXP_TOP = EXP_CALC_W'(IN_W - 1 - FRAC_BITS);

  conv_state_e                  state_q, state_d;
  logic [IN_W-1:0]              mag_q, mag_d;
  logic [SH_W-1:0]              sh_q, sh_d;
  logic                         sign_q, sign_d;
  logic [63:0]                  out_double_q, out_double_d;
  logic                         out_valid_q, out_valid_d;

  logic                         w_in_sign;
  logic [IN_W-1:0]              w_in_mag;
  logic signed [EXP_CALC_W-1:0] w_exp;
  logic [63:0]                  w_packed;

  assign w_in_sign = (SIGNED != 0) && bus.in_data[IN_W-1];
  // Most-negative input negates to 2^(IN_W-1), still correct as unsigned
  assign w_in_mag  = w_in_sign ? (~bus.in_data + IN_W'(1)) : bus.in_data;
  assign w_exp     = c_EXP_TOP - EXP_CALC_W'(sh_q);

  fp64_pack_round #(
    .MAG_W (IN_W)
  ) u_pack_round (
    .mag_i    (mag_q),
    .sign_i   (sign_q),
    .exp_i    (w_exp),
    .double_o (w_packed)
  );

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_double = out_double_q;

  // Next-state and datapath updates for the accept/normalise/pack/hold sequence
  always_comb begin
    state_d      = state_q;
    mag_d        = mag_q;
    sh_d         = sh_q;
    sign_d       = sign_q;
    out_double_d = out_double_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sign_d  = w_in_sign;
          mag_d   = w_in_mag;
          sh_d    = '0;
          state_d = (w_in_mag == '0) ? ST_PACK : ST_NORM;
        end
      end
      ST_NORM: begin
        if (!mag_q[IN_W-1]) begin
          mag_d = mag_q << 1;
          sh_d  = sh_q + SH_W'(1);
        end else begin
          state_d = ST_PACK;
        end
      end
      ST_PACK: begin
        out_double_d = w_packed;
        out_valid_d  = 1'b1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sample in flight
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mag_q        <= '0;
      sh_q         <= '0;
      sign_q       <= 1'b0;
      out_double_q <= 64'h0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mag_q        <= mag_d;
      sh_q         <= sh_d;
      sign_q       <= sign_d;
      out_double_q <= out_double_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_to_double_conv.sv
// ============================================================================
// Module      : tb_fixed_to_double_conv
// Description : Scoreboard bench for fixed_to_double_conv, one 16-bit signed
//               Q1.15 instance and one 64-bit unsigned integer instance.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fixed_to_double_conv;

  logic clk_operation = 1'b0;
  logic rst;

  always #5 clk_operation = ~clk_operation;

  fixed_to_double_conv_if #(.IN_W(16)) if16 ();
  fixed_to_double_conv_if #(.IN_W(64)) if64 ();

  fixed_to_double_conv #(.IN_W(16), .FRAC_BITS(15), .SIGNED(1)) dut16 (
    .clk_operation (clk_operation),
    .rst           (rst),
    .bus           (if16)
  );

  fixed_to_double_conv #(.IN_W(64), .FRAC_BITS(0), .SIGNED(0)) dut64 (
    .clk_operation (clk_operation),
    .rst           (rst),
    .bus           (if64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp16_q[$];
  int          lat16_q[$];
  logic [63:0] exp64_q[$];
  int          lat64_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Q1.15 value computed as a real number, then encoded by the simulator
  function automatic logic [63:0] ref16(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    return $realtobits(real'(v) / 32768.0);
  endfunction

  // Unsigned 64-bit integer to double with round-half-to-even
  function automatic logic [63:0] ref64(input logic [63:0] m);
    int p;
    int s;
    logic [63:0] q;
    logic [63:0] r;
    logic [63:0] half;
    if (m == 64'd0) return 64'd0;
    p = 63;
    while (!m[p]) p--;
    if (p <= 52) begin
      q = m << (52 - p);
    end else begin
      s    = p - 52;
      q    = m >> s;
      r    = m & ((64'd1 << s) - 64'd1);
      half = 64'd1 << (s - 1);
      if (r > half || (r == half && q[0])) q = q + 64'd1;
      if (q[53]) begin
        q = q >> 1;
        p++;
      end
    end
    return {1'b0, 11'(p + 1023), q[51:0]};
  endfunction

  // Edges from accept to first valid output: 1 for zero, else leading zeros + 2
  function automatic int lat_of(input logic [63:0] mag, input int w);
    for (int i = w - 1; i >= 0; i--)
      if (mag[i]) return (w - 1 - i) + 2;
    return 1;
  endfunction

  function automatic logic [63:0] abs16(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    return 64'((v < 0) ? -v : v);
  endfunction

  // Monitor for the 16-bit instance
  initial begin : mon16
    int  cyc;
    int  start;
    bit  waiting;
    bit  prev;
    logic [63:0] ev;
    int  el;
    cyc = 0; start = 0; waiting = 0; prev = 0;
    forever begin
      @(negedge clk_operation);
      cyc++;
      if (rst) begin
        waiting = 0;
        prev    = 0;
      end else begin
        if (!waiting && if16.in_valid && if16.in_ready) begin
          waiting = 1;
          start   = cyc;
        end
        if (if16.out_valid && !prev) begin
          if (!waiting || exp16_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL out16_unexpected: got out_valid=1 expected no output");
          end else begin
            ev = exp16_q.pop_front();
            el = lat16_q.pop_front();
            chk("out16_value", if16.out_double, ev);
            chk("out16_latency", 64'(cyc - start - 1), 64'(el));
            waiting = 0;
          end
        end
        prev = if16.out_valid;
      end
    end
  end

  // Monitor for the 64-bit instance
  initial begin : mon64
    int  cyc;
    int  start;
    bit  waiting;
    bit  prev;
    logic [63:0] ev;
    int  el;
    cyc = 0; start = 0; waiting = 0; prev = 0;
    forever begin
      @(negedge clk_operation);
      cyc++;
      if (rst) begin
        waiting = 0;
        prev    = 0;
      end else begin
        if (!waiting && if64.in_valid && if64.in_ready) begin
          waiting = 1;
          start   = cyc;
        end
        if (if64.out_valid && !prev) begin
          if (!waiting || exp64_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL out64_unexpected: got out_valid=1 expected no output");
          end else begin
            ev = exp64_q.pop_front();
            el = lat64_q.pop_front();
            chk("out64_value", if64.out_double, ev);
            chk("out64_latency", 64'(cyc - start - 1), 64'(el));
            waiting = 0;
          end
        end
        prev = if64.out_valid;
      end
    end
  end

  task automatic send16(input logic [15:0] d, input logic [63:0] ev, input int el, input int hold);
    int n;
    exp16_q.push_back(ev);
    lat16_q.push_back(el);
    if16.in_data  = d;
    if16.in_valid = 1'b1;
    @(posedge clk_operation); #1;
    if16.in_valid = 1'b0;
    if16.in_data  = 16'($urandom);
    n = 0;
    while (!if16.out_valid && n < 100) begin
      @(posedge clk_operation); #1;
      n++;
    end
    if (!if16.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL out16_timeout: got no out_valid within 100 cycles expected a result");
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk_operation); #1;
      chk("hold16_valid", 64'(if16.out_valid), 64'd1);
      chk("hold16_value", if16.out_double, ev);
      chk("hold16_in_ready", 64'(if16.in_ready), 64'd0);
      chk("hold16_busy", 64'(if16.busy), 64'd1);
    end
    if16.out_ready = 1'b1;
    @(posedge clk_operation); #1;
    if16.out_ready = 1'b0;
    chk("drain16_valid", 64'(if16.out_valid), 64'd0);
    @(posedge clk_operation); #1;
    chk("drain16_in_ready", 64'(if16.in_ready), 64'd1);
  endtask

  task automatic send64(input logic [63:0] d, input logic [63:0] ev, input int el);
    int n;
    exp64_q.push_back(ev);
    lat64_q.push_back(el);
    if64.in_data  = d;
    if64.in_valid = 1'b1;
    @(posedge clk_operation); #1;
    if64.in_valid = 1'b0;
    if64.in_data  = {$urandom, $urandom};
    n = 0;
    while (!if64.out_valid && n < 100) begin
      @(posedge clk_operation); #1;
      n++;
    end
    if (!if64.out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL out64_timeout: got no out_valid within 100 cycles expected a result");
    end
    if64.out_ready = 1'b1;
    @(posedge clk_operation); #1;
    if64.out_ready = 1'b0;
    chk("drain64_valid", 64'(if64.out_valid), 64'd0);
  endtask

  initial begin : stim
    logic [15:0] d16;
    logic [63:0] d64;
    rst            = 1'b1;
    if16.in_data   = '0;
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b0;
    if64.in_data   = '0;
    if64.in_valid  = 1'b0;
    if64.out_ready = 1'b0;

    repeat (3) @(posedge clk_operation);
    #1;
    chk("rst16_in_ready", 64'(if16.in_ready), 64'd1);
    chk("rst16_out_valid", 64'(if16.out_valid), 64'd0);
    chk("rst16_out_double", if16.out_double, 64'd0);
    chk("rst16_busy", 64'(if16.busy), 64'd0);
    chk("rst64_in_ready", 64'(if64.in_ready), 64'd1);
    chk("rst64_out_valid", 64'(if64.out_valid), 64'd0);
    chk("rst64_out_double", if64.out_double, 64'd0);
    chk("rst64_busy", 64'(if64.busy), 64'd0);
    rst = 1'b0;
    @(posedge clk_operation); #1;

    // Directed Q1.15 cases
    send16(16'h4000, 64'h3FE0000000000000, 3, 0);
    send16(16'h8000, 64'hBFF0000000000000, 2, 0);
    send16(16'h7FFF, 64'h3FEFFFC000000000, 3, 0);
    send16(16'h0001, 64'h3F00000000000000, 17, 0);
    send16(16'h0000, 64'h0000000000000000, 1, 0);
    send16(16'hC000, 64'hBFE0000000000000, 3, 5);

    // Reset during normalisation aborts the sample
    if16.in_data  = 16'h0001;
    if16.in_valid = 1'b1;
    @(posedge clk_operation); #1;
    if16.in_valid = 1'b0;
    repeat (4) @(posedge clk_operation);
    #1;
    chk("abort16_busy_before", 64'(if16.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk_operation); #1;
    rst = 1'b0;
    chk("abort16_in_ready", 64'(if16.in_ready), 64'd1);
    chk("abort16_out_valid", 64'(if16.out_valid), 64'd0);
    chk("abort16_busy", 64'(if16.busy), 64'd0);
    repeat (25) @(posedge clk_operation);
    #1;
    chk("abort16_no_output", 64'(if16.out_valid), 64'd0);
    send16(16'h4000, 64'h3FE0000000000000, 3, 0);

    // Directed wide-input rounding cases
    send64(64'hFFFFFFFFFFFFFFFF, 64'h43F0000000000000, 2);
    send64(64'h0020000000000001, 64'h4340000000000000, 12);
    send64(64'h0000000000000000, 64'h0000000000000000, 1);

    // Randomised traffic against the reference models
    for (int i = 0; i < 30; i++) begin
      d16 = 16'($urandom);
      if (i % 7 == 0) d16 = d16 >> $urandom_range(0, 15);
      send16(d16, ref16(d16), lat_of(abs16(d16), 16), 0);
    end
    for (int i = 0; i < 25; i++) begin
      d64 = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (i % 5 == 0) d64 = (d64 | 64'h8000000000000000) & ~64'h3FF | 64'h400;
      send64(d64, ref64(d64), lat_of(d64, 64));
    end

    repeat (5) @(posedge clk_operation);
    #1;
    chk("sb16_empty", 64'(exp16_q.size()), 64'd0);
    chk("sb64_empty", 64'(exp64_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
